digi_pot_ramp_ctrl: RTL

- Sequencer that drives the digi_pot wiper to a requested target value.
- Accepts one target per valid/ready handshake.
- Either loads the target directly or ramps to it one LSB at a time, issuing inc/dec pulses at a programmable rate; closes the loop on the pot's resistance_out.
- Sits between system control logic and a single digi_pot instance. Reports completion, step count and error status.

---
 rtl/digi_pot_ramp_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/digi_pot_ramp_ctrl.sv
// Wiper sequencer for a single digi_pot: direct load or one-LSB ramp to a target,
// closing the loop on the pot's resistance_out and reporting done/err/step count.
//
// state | meaning
// IDLE  | ready for a request
// LOAD  | pot_load pulse with target on pot_din
// LWAIT | settle after load, then compare feedback
// CHECK | compare feedback to target, detect stall
// STEP  | one inc/dec pulse, capture feedback
// WAIT  | pad the step out to STEP_DIV cycles
// DONE  | done pulse, err valid
module digi_pot_ramp_ctrl #(
    parameter int WIDTH    = 8,
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic             req_mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] pot_fb,
    output logic             pot_inc,
    output logic             pot_dec,
    output logic             pot_load,
    output logic [WIDTH-1:0] pot_din,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [8:0]       step_cnt
);

    typedef enum logic [2:0] {
        IDLE, LOAD, LWAIT, CHECK, STEP, WAIT, DONE
    } state_t;

    // LWAIT spans STEP_DIV cycles so a direct load completes at STEP_DIV+2
    localparam logic [7:0] LWAIT_CNT = 8'(STEP_DIV - 1);
    localparam logic [7:0] WAIT_CNT  = 8'((STEP_DIV > 2) ? (STEP_DIV - 3) : 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             stepped_q, stepped_d;
    logic [7:0]       tmr_q, tmr_d;
    logic             err_d, inc_d, dec_d;
    logic [8:0]       cnt_d;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        cap_d     = cap_q;
        stepped_d = stepped_q;
        tmr_d     = tmr_q;
        err_d     = 1'b0;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        cnt_d     = step_cnt;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    target_d  = req_target;
                    stepped_d = 1'b0;
                    cnt_d     = 9'd0;
                    state_d   = req_mode ? LOAD : CHECK;
                end
            end
            LOAD: begin
                tmr_d   = LWAIT_CNT;
                state_d = LWAIT;
            end
            LWAIT: begin
                if (tmr_q == 8'd0) begin
                    state_d = DONE;
                    err_d   = (pot_fb != target_q);
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            CHECK: begin
                if (pot_fb == target_q) begin
                    state_d = DONE;
                end else if (stepped_q && (pot_fb == cap_q)) begin
                    // last pulse did not move the wiper: saturated or stuck pot
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = STEP;
                    inc_d   = (pot_fb < target_q);
                    dec_d   = (pot_fb > target_q);
                end
            end
            STEP: begin
                cap_d     = pot_fb;
                stepped_d = 1'b1;
                if (STEP_DIV == 2) begin
                    state_d = CHECK;
                end else begin
                    tmr_d   = WAIT_CNT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (tmr_q == 8'd0) state_d = CHECK;
                else               tmr_d   = tmr_q - 8'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE) && (state_q != DONE)) begin
            state_d = DONE;
            err_d   = 1'b1;
            inc_d   = 1'b0;
            dec_d   = 1'b0;
        end

        if ((inc_d || dec_d) && (cnt_d != 9'd511)) cnt_d = cnt_d + 9'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            target_q  <= '0;
            cap_q     <= '0;
            stepped_q <= 1'b0;
            tmr_q     <= 8'd0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pot_inc   <= 1'b0;
            pot_dec   <= 1'b0;
            pot_load  <= 1'b0;
            pot_din   <= '0;
            step_cnt  <= 9'd0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            cap_q     <= cap_d;
            stepped_q <= stepped_d;
            tmr_q     <= tmr_d;
            req_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
            err       <= err_d;
            pot_inc   <= inc_d;
            pot_dec   <= dec_d;
            pot_load  <= (state_d == LOAD);
            if (state_d == LOAD) pot_din <= target_d;
            step_cnt  <= cnt_d;
        end
    end

endmodule
